// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder_unit. The tb or datapath master drives
// the request side and the adder (slave) returns the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  // Handshake: start is sampled only on an edge where busy=0. An accepted
  // start raises busy the next cycle. busy drops in the same cycle that done
  // pulses for exactly one cycle. S/cout/ovf are valid from done until the
  // next done, and start may be high in the done cycle.
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, cin, sub,
    input  S, cout, ovf, busy, done
  );

  modport slave (
    input  start, A, B, cin, sub,
    output S, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_adder_unit.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a chain of
// one-bit full-adder cells, with the inter-digit carry held in a register.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus,
  output logic           state_dbg
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic [CW-1:0]    count_q;
  logic             accept;
  logic             last;
  int               dig_lo;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] sum_dig;
  logic [DIGIT:0]   c;

  assign state_dbg = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (count_q == CW'(N - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the current digit of both captured operands.
  always_comb begin
    dig_lo   = int'(count_q) * DIGIT;
    a_dig    = a_q[dig_lo +: DIGIT];
    b_dig    = b_q[dig_lo +: DIGIT];
    res_next = res_q;
    res_next[dig_lo +: DIGIT] = sum_dig;
  end

  assign c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder_cell u_fa (
      .a  (a_dig[i]),
      .b  (b_dig[i]),
      .ci (c[i]),
      .s  (sum_dig[i]),
      .co (c[i+1])
    );
  end

  // Datapath. B is stored pre-inverted for subtract, so RUN only ever adds;
  // in the last digit c[DIGIT-1] is the carry into the word MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      bus.S    <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        a_q      <= bus.A;
        b_q      <= bus.B ^ {WIDTH{bus.sub}};
        carry_q  <= bus.cin ^ bus.sub;
        count_q  <= '0;
        bus.busy <= 1'b1;
      end else if (state_q == RUN) begin
        res_q   <= res_next;
        carry_q <= c[DIGIT];
        count_q <= count_q + 1'b1;
        if (last) begin
          count_q  <= '0;
          bus.S    <= res_next;
          bus.cout <= c[DIGIT];
          bus.ovf  <= c[DIGIT-1] ^ c[DIGIT];
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
      end
    end
  end
endmodule
